// File: rtl/infobus_tx.sv
// infobus_tx: producer end of the 69-bit info bus.
// Generates XVGA raster timing on vclock, clamps hand-tracker samples into a
// shadow set, and commits the shadow set to the bus once per frame at the
// last active pixel, so consumers see constant hand data for a whole frame.
// Optional feature macro: INFOBUS_STALE_TIMEOUT_EN -- after STALE_FRAMES
// frames without hand_valid, each commit loads the centre position instead.
// Raster geometry is parameterised; the defaults are the 1024x768 XVGA timing.
module infobus_tx #(
  parameter int STALE_FRAMES = 15,
  parameter int H_ACTIVE     = 1024,
  parameter int H_SYNC_START = 1048,
  parameter int H_SYNC_END   = 1183,
  parameter int H_TOTAL      = 1344,
  parameter int V_ACTIVE     = 768,
  parameter int V_SYNC_START = 771,
  parameter int V_SYNC_END   = 776,
  parameter int V_TOTAL      = 806
) (
  input  logic        vclock,
  input  logic        reset,
  input  logic        hand_valid,
  input  logic [11:0] hand1x_in,
  input  logic [11:0] hand2x_in,
  input  logic [10:0] hand1y_in,
  input  logic [10:0] hand2y_in,
  input  logic        grab1_in,
  input  logic        grab2_in,
  output logic [68:0] infoout
);

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_COMMIT = 11'(H_ACTIVE - 1);
  localparam logic [10:0] H_BLANK  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SS     = 11'(H_SYNC_START);
  localparam logic [10:0] H_SE     = 11'(H_SYNC_END);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_COMMIT = 10'(V_ACTIVE - 1);
  localparam logic [9:0]  V_BLANK  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_SS     = 10'(V_SYNC_START);
  localparam logic [9:0]  V_SE     = 10'(V_SYNC_END);

  localparam logic [10:0] X_MAX = 11'd1023;
  localparam logic [10:0] X_CTR = 11'd512;
  localparam logic [9:0]  Y_MAX = 10'd767;
  localparam logic [9:0]  Y_CTR = 10'd384;

  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        rst_q;

  logic [10:0] sh1x_q, sh2x_q, b1x_q, b2x_q;
  logic [9:0]  sh1y_q, sh2y_q, b1y_q, b2y_q;
  logic        sg1_q, sg2_q, bg1_q, bg2_q;

  logic        commit;
  logic        stale_hit;

  function automatic logic [10:0] clamp_x(input logic [11:0] x);
    clamp_x = (x > 12'd1023) ? X_MAX : x[10:0];
  endfunction

  function automatic logic [9:0] clamp_y(input logic [10:0] y);
    clamp_y = (y > 11'd767) ? Y_MAX : y[9:0];
  endfunction

  // Next raster position plus sync/blank decoded from it, so the registered
  // sync/blank always belong to the same pixel as the registered counters.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = 11'd0;
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end
    hsync_d = !((hcount_d >= H_SS) && (hcount_d <= H_SE));
    vsync_d = !((vcount_d >= V_SS) && (vcount_d <= V_SE));
    blank_d = (hcount_d >= H_BLANK) || (vcount_d >= V_BLANK);
  end

  // Raster timing registers and the registered copy of reset for bit 68.
  always_ff @(posedge vclock) begin
    rst_q <= reset;
    if (reset) begin
      hcount_q <= 11'd0;
      vcount_q <= 10'd0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      blank_q  <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      blank_q  <= blank_d;
    end
  end

  assign commit = (hcount_q == H_COMMIT) && (vcount_q == V_COMMIT);

`ifdef INFOBUS_STALE_TIMEOUT_EN
  localparam int SC_W = ($clog2(STALE_FRAMES + 1) < 1) ? 1 : $clog2(STALE_FRAMES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STALE_FRAMES);
  logic [SC_W-1:0] stale_q;

  // Commits seen since the last tracker update; saturates at STALE_FRAMES.
  always_ff @(posedge vclock) begin
    if (reset)
      stale_q <= '0;
    else if (hand_valid)
      stale_q <= '0;
    else if (commit && (stale_q < SC_MAX))
      stale_q <= stale_q + 1'b1;
  end

  assign stale_hit = commit && (stale_q >= SC_MAX);
`else
  assign stale_hit = 1'b0;
`endif

  // Shadow capture: a new sample wins over a stale re-centre on the same cycle.
  always_ff @(posedge vclock) begin
    if (reset) begin
      sh1x_q <= X_CTR;
      sh1y_q <= Y_CTR;
      sh2x_q <= X_CTR;
      sh2y_q <= Y_CTR;
      sg1_q  <= 1'b0;
      sg2_q  <= 1'b0;
    end else if (hand_valid) begin
      sh1x_q <= clamp_x(hand1x_in);
      sh1y_q <= clamp_y(hand1y_in);
      sh2x_q <= clamp_x(hand2x_in);
      sh2y_q <= clamp_y(hand2y_in);
      sg1_q  <= grab1_in;
      sg2_q  <= grab2_in;
    end else if (stale_hit) begin
      sh1x_q <= X_CTR;
      sh1y_q <= Y_CTR;
      sh2x_q <= X_CTR;
      sh2y_q <= Y_CTR;
      sg1_q  <= 1'b0;
      sg2_q  <= 1'b0;
    end
  end

  // Bus hand fields change only at the commit point, from the pre-commit shadow.
  always_ff @(posedge vclock) begin
    if (reset || stale_hit) begin
      b1x_q <= X_CTR;
      b1y_q <= Y_CTR;
      b2x_q <= X_CTR;
      b2y_q <= Y_CTR;
      bg1_q <= 1'b0;
      bg2_q <= 1'b0;
    end else if (commit) begin
      b1x_q <= sh1x_q;
      b1y_q <= sh1y_q;
      b2x_q <= sh2x_q;
      b2y_q <= sh2y_q;
      bg1_q <= sg1_q;
      bg2_q <= sg2_q;
    end
  end

  assign infoout = {rst_q, hcount_q, vcount_q, hsync_q, vsync_q, blank_q,
                    b1x_q, b1y_q, b2x_q, b2y_q, bg2_q, bg1_q};

endmodule

// File: tb/tb_infobus_tx.sv
// Bench for infobus_tx with a reduced raster so many frames fit in a short run.
// A pixel-index model predicts every bus field each cycle; directed literal
// checks pin the raster counts and the hand-data scenarios.
module tb_infobus_tx;

  localparam int HA = 40, HSS = 44, HSE = 49, HT = 56;
  localparam int VA = 12, VSS = 14, VSE = 15, VT = 18;
  localparam int SF = 2;
  localparam int FRAME = HT * VT;

  logic        vclock;
  logic        reset;
  logic        hand_valid;
  logic [11:0] hand1x_in, hand2x_in;
  logic [10:0] hand1y_in, hand2y_in;
  logic        grab1_in, grab2_in;
  logic [68:0] infoout;

  int checks = 0;
  int errors = 0;
  int fail_prints = 0;

  infobus_tx #(
    .STALE_FRAMES(SF),
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT)
  ) dut (
    .vclock(vclock), .reset(reset), .hand_valid(hand_valid),
    .hand1x_in(hand1x_in), .hand2x_in(hand2x_in),
    .hand1y_in(hand1y_in), .hand2y_in(hand2y_in),
    .grab1_in(grab1_in), .grab2_in(grab2_in),
    .infoout(infoout)
  );

  initial vclock = 1'b0;
  always #5 vclock = ~vclock;

  logic [10:0] o_h, o_1x, o_2x;
  logic [9:0]  o_v, o_1y, o_2y;
  logic        o_hs, o_vs, o_bl, o_rst, o_g1, o_g2;
  assign o_rst = infoout[68];
  assign o_h   = infoout[67:57];
  assign o_v   = infoout[56:47];
  assign o_hs  = infoout[46];
  assign o_vs  = infoout[45];
  assign o_bl  = infoout[44];
  assign o_1x  = infoout[43:33];
  assign o_1y  = infoout[32:23];
  assign o_2x  = infoout[22:12];
  assign o_2y  = infoout[11:2];
  assign o_g2  = infoout[1];
  assign o_g1  = infoout[0];

  // Behavioural model: position is just the pixel index since reset.
  int mcyc, m_rst, m_stale;
  int s1x, s1y, s2x, s2y, sg1, sg2;
  int b1x, b1y, b2x, b2y, bg1, bg2;
  bit mvalid = 1'b0;

  function automatic int clampv(input int val, input int mx);
    return (val > mx) ? mx : val;
  endfunction

  initial begin
    forever begin
      @(posedge vclock);
      if (reset) begin
        mcyc = 0; m_rst = 1; m_stale = 0; mvalid = 1'b1;
        s1x = 512; s1y = 384; s2x = 512; s2y = 384; sg1 = 0; sg2 = 0;
        b1x = 512; b1y = 384; b2x = 512; b2y = 384; bg1 = 0; bg2 = 0;
      end else if (mvalid) begin
        bit is_commit, go_centre;
        is_commit = ((mcyc % HT) == HA - 1) && (((mcyc / HT) % VT) == VA - 1);
        go_centre = 1'b0;
`ifdef INFOBUS_STALE_TIMEOUT_EN
        go_centre = is_commit && (m_stale >= SF);
`endif
        if (go_centre) begin
          b1x = 512; b1y = 384; b2x = 512; b2y = 384; bg1 = 0; bg2 = 0;
        end else if (is_commit) begin
          b1x = s1x; b1y = s1y; b2x = s2x; b2y = s2y; bg1 = sg1; bg2 = sg2;
        end
        if (hand_valid) begin
          s1x = clampv(int'(hand1x_in), 1023); s1y = clampv(int'(hand1y_in), 767);
          s2x = clampv(int'(hand2x_in), 1023); s2y = clampv(int'(hand2y_in), 767);
          sg1 = int'(grab1_in); sg2 = int'(grab2_in);
        end else if (go_centre) begin
          s1x = 512; s1y = 384; s2x = 512; s2y = 384; sg1 = 0; sg2 = 0;
        end
        if (hand_valid) m_stale = 0;
        else if (is_commit && m_stale < SF) m_stale = m_stale + 1;
        mcyc = mcyc + 1;
        m_rst = 0;
      end
    end
  end

  // Per-cycle compare of the whole bus against the model.
  initial begin
    forever begin
      @(negedge vclock);
      if (mvalid) begin
        int h, v;
        logic [68:0] exp_bus;
        h = mcyc % HT;
        v = (mcyc / HT) % VT;
        exp_bus = {1'(m_rst), 11'(h), 10'(v),
                   1'(!(h >= HSS && h <= HSE)), 1'(!(v >= VSS && v <= VSE)),
                   1'(h >= HA || v >= VA),
                   11'(b1x), 10'(b1y), 11'(b2x), 10'(b2y), 1'(bg2), 1'(bg1)};
        checks++;
        if (infoout !== exp_bus) begin
          errors++;
          if (fail_prints < 20) begin
            fail_prints++;
            $display("FAIL bus_model t=%0t actual=%h required=%h", $time, infoout, exp_bus);
          end
        end
      end
    end
  end

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp_v);
    end
  endtask

  task automatic wait_pos(input int h, input int v, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge vclock);
      n++;
    end while (!(o_h == 11'(h) && o_v == 10'(v)) && n < 3 * FRAME);
    if (n >= 3 * FRAME) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=none required=h%0d_v%0d", nm, h, v);
    end
  endtask

  task automatic set_hands(input int x1, input int y1, input int g1,
                           input int x2, input int y2, input int g2);
    hand1x_in = 12'(x1); hand1y_in = 11'(y1); grab1_in = 1'(g1);
    hand2x_in = 12'(x2); hand2y_in = 11'(y2); grab2_in = 1'(g2);
  endtask

  task automatic strobe(input int x1, input int y1, input int g1,
                        input int x2, input int y2, input int g2);
    set_hands(x1, y1, g1, x2, y2, g2);
    hand_valid = 1'b1;
    @(negedge vclock);
    hand_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_lo, vs_lo, bl_hi, hmax, vmax, r1, r2;
    logic prev_vs;
    reset = 1'b1;
    hand_valid = 1'b0;
    set_hands(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge vclock);
    pin("rst_bit", 32'(o_rst), 1);
    pin("rst_hcount", 32'(o_h), 0);
    pin("rst_vcount", 32'(o_v), 0);
    pin("rst_hsync", 32'(o_hs), 1);
    pin("rst_vsync", 32'(o_vs), 1);
    pin("rst_blank", 32'(o_bl), 0);
    pin("rst_hand1x", 32'(o_1x), 512);
    pin("rst_hand2y", 32'(o_2y), 384);
    pin("rst_grabs", 32'({o_g2, o_g1}), 0);
    reset = 1'b0;
    @(negedge vclock);
    pin("rel_bit", 32'(o_rst), 0);
    pin("rel_hcount", 32'(o_h), 1);

    // Two full frames of raster statistics.
    wait_pos(0, 0, "frame_start");
    hs_lo = 0; vs_lo = 0; bl_hi = 0; hmax = 0; vmax = 0; r1 = -1; r2 = -1;
    prev_vs = o_vs;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (!o_hs) hs_lo++;
      if (!o_vs) vs_lo++;
      if (o_bl) bl_hi++;
      if (int'(o_h) > hmax) hmax = int'(o_h);
      if (int'(o_v) > vmax) vmax = int'(o_v);
      if (!prev_vs && o_vs) begin
        if (r1 < 0) r1 = i;
        else r2 = i;
      end
      prev_vs = o_vs;
      @(negedge vclock);
    end
    pin("hsync_low_cycles", 32'(hs_lo), 216);
    pin("vsync_low_cycles", 32'(vs_lo), 224);
    pin("blank_cycles", 32'(bl_hi), 1056);
    pin("hcount_max", 32'(hmax), 55);
    pin("vcount_max", 32'(vmax), 17);
    pin("frame_length", 32'(r2 - r1), 1008);

    // Commit timing.
    wait_pos(0, 5, "commit_strobe");
    strobe(300, 200, 1, 512, 384, 0);
    wait_pos(HA - 1, VA - 1, "commit_cycle");
    pin("pre_commit_hand1x", 32'(o_1x), 512);
    pin("pre_commit_hand1y", 32'(o_1y), 384);
    pin("pre_commit_grab1", 32'(o_g1), 0);
    @(negedge vclock);
    pin("post_commit_hcount", 32'(o_h), HA);
    pin("post_commit_hand1x", 32'(o_1x), 300);
    pin("post_commit_hand1y", 32'(o_1y), 200);
    pin("post_commit_grab1", 32'(o_g1), 1);

    // Clamping.
    wait_pos(0, 2, "clamp_strobe");
    strobe(300, 200, 1, 4000, 2000, 0);
    wait_pos(HA, VA - 1, "clamp_commit");
    pin("clamp_hand2x", 32'(o_2x), 1023);
    pin("clamp_hand2y", 32'(o_2y), 767);

    // Last strobe in a frame wins; exact maxima pass, one above saturates.
    wait_pos(0, 2, "multi_a");
    strobe(300, 200, 1, 100, 50, 1);
    wait_pos(0, 4, "multi_b");
    strobe(300, 768, 1, 1023, 767, 1);
    wait_pos(HA, VA - 1, "multi_commit");
    pin("edge_hand1y", 32'(o_1y), 767);
    pin("last_wins_hand2x", 32'(o_2x), 1023);
    pin("last_wins_hand2y", 32'(o_2y), 767);
    pin("last_wins_grab2", 32'(o_g2), 1);

    wait_pos(0, 2, "mix_strobe");
    strobe(300, 200, 1, 1024, 5, 0);
    wait_pos(HA, VA - 1, "mix_commit");
    pin("mix_hand2x", 32'(o_2x), 1023);
    pin("mix_hand2y", 32'(o_2y), 5);
    pin("mix_grab2", 32'(o_g2), 0);

    // Capture on the commit cycle.
    wait_pos(HA - 1, VA - 1, "cap_cycle");
    set_hands(700, 200, 1, 1024, 5, 0);
    hand_valid = 1'b1;
    @(negedge vclock);
    hand_valid = 1'b0;
    pin("cap_same_frame_hand1x", 32'(o_1x), 300);
    wait_pos(HA, VA - 1, "cap_next_commit");
    pin("cap_next_frame_hand1x", 32'(o_1x), 700);

    // Mid-frame reset.
    wait_pos(0, 2, "mid_strobe");
    strobe(300, 200, 1, 512, 384, 0);
    wait_pos(HA, VA - 1, "mid_commit");
    pin("mid_pre_hand1x", 32'(o_1x), 300);
    wait_pos(10, 6, "mid_point");
    reset = 1'b1;
    @(negedge vclock);
    reset = 1'b0;
    pin("mid_rst_bit", 32'(o_rst), 1);
    pin("mid_rst_hcount", 32'(o_h), 0);
    pin("mid_rst_vcount", 32'(o_v), 0);
    pin("mid_rst_hand1x", 32'(o_1x), 512);
    @(negedge vclock);
    pin("mid_rel_bit", 32'(o_rst), 0);

    // Stale behaviour: commit 300 then stop strobing.
    wait_pos(0, 2, "stale_strobe");
    strobe(300, 200, 1, 512, 384, 0);
    wait_pos(HA, VA - 1, "stale_c0");
    pin("stale_c0_hand1x", 32'(o_1x), 300);
    wait_pos(HA, VA - 1, "stale_c1");
    pin("stale_c1_hand1x", 32'(o_1x), 300);
    wait_pos(HA, VA - 1, "stale_c2");
`ifdef INFOBUS_STALE_TIMEOUT_EN
    pin("stale_c2_hand1x", 32'(o_1x), 512);
    pin("stale_c2_hand1y", 32'(o_1y), 384);
    pin("stale_c2_grab1", 32'(o_g1), 0);
`else
    pin("hold_c2_hand1x", 32'(o_1x), 300);
`endif
    repeat (3) wait_pos(HA, VA - 1, "stale_more");
`ifdef INFOBUS_STALE_TIMEOUT_EN
    pin("stale_c5_hand1x", 32'(o_1x), 512);
`else
    pin("hold_c5_hand1x", 32'(o_1x), 300);
    pin("hold_c5_grab1", 32'(o_g1), 1);
`endif

    @(negedge vclock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/infobus_tx.md
# infobus_tx

Producer end of the 69-bit `infoin` user/video info bus that scroll and game blocks consume. Generates 1024x768 XVGA raster timing (hcount, vcount, hsync, vsync, blank) on `vclock`. Samples hand-tracker positions and grab flags, clamps them, and commits them to the bus once per frame, so consumers see constant hand data for an entire active frame. Sits between the camera/hand tracker and all bus consumers.

## Interface
- `STALE_FRAMES`, 15: number of frames without a tracker update before the hands are forced to the centre position (used only with the timeout feature).
- `vclock`  in  1  pixel clock, 65 MHz.
- `reset`  in  1  synchronous, active-high.
- `hand_valid`  in  1  one-cycle strobe; the hand inputs below are valid on this cycle.
- `hand1x_in`, `hand2x_in`  in  12 each  unsigned raw x.
- `hand1y_in`, `hand2y_in`  in  11 each  unsigned raw y.
- `grab1_in`, `grab2_in`  in  1 each  raw grab flags, sampled with `hand_valid`.
- `infoout`  out  69  packed bus, MSB first:
  - reset[68], hcount[67:57], vcount[56:47], hsync[46], vsync[45], blank[44]
  - hand1x[43:33], hand1y[32:23], hand2x[22:12], hand2y[11:2]
  - grab2[1], grab1[0]

## Operation
- **Raster counters.**
  - hcount counts 0..1343, then wraps to 0. At that wrap, vcount increments.
  - vcount counts 0..805, then wraps to 0.
- **Sync and blank** (all active-low syncs):
  - hsync = 0 iff 1048 ≤ hcount ≤ 1183.
  - vsync = 0 iff 771 ≤ vcount ≤ 776.
  - blank = 1 iff hcount ≥ 1024 or vcount ≥ 768.
- **Bus reset bit.** Bit 68 is a registered copy of `reset`.
- **Shadow capture.** On `hand_valid`, each sample is clamped into a shadow register:
  - x to 0..1023; y to 0..767. A value above the maximum saturates to the maximum.
  - Grab flags are copied unchanged.
- **Commit.** On the cycle where hcount = 1023 and vcount = 767 (last active pixel), the shadow values are copied to the bus hand/grab fields.
  - The fields therefore change only while blank = 1.
- **Simultaneous capture and commit.** If `hand_valid` arrives on the commit cycle, the commit uses the shadow value from before that cycle. The new sample appears at the next frame's commit.
- **Multiple updates per frame.** If several `hand_valid` strobes arrive in one frame, the last one wins.
- **Reset mid-frame.** Counters restart at 0,0, the shadow and bus hand fields return to their reset values, and the first commit occurs at the next 1023/767.

## Timing
- Every `infoout` field is registered. The timing fields are mutually consistent for the same pixel (no skew between counters and sync/blank).
- **Reset values** (on the cycle after `reset` is sampled high):
  - hcount = 0, vcount = 0, hsync = 1, vsync = 1, blank = 0, reset bit = 1.
  - hand1x = hand2x = 512, hand1y = hand2y = 384, grab1 = grab2 = 0.
  - Shadow registers use the same values.
- **Latency.**
  - `hand_valid` to shadow: 1 cycle.
  - Shadow to bus: the next commit point, worst case 1344×806 cycles.
  - Commit cycle to bus change: 1 cycle (bus shows new hand data at hcount = 1024, vcount = 767).
- **Frame length:** 1,083,264 cycles. vsync low for 6 lines = 8064 cycles.
- A consumer clocked on the rising edge of vsync (at the end of the sync pulse) always sees committed, stable hand data.

## Configuration
- **`INFOBUS_STALE_TIMEOUT_EN` defined:**
  - A frame counter increments at each commit point and clears on any `hand_valid`.
  - When the counter reaches `STALE_FRAMES`, that commit loads centre values (512, 384, 384/512, grabs 0) into both the bus fields and the shadow. This repeats every stale frame until `hand_valid` arrives.
  - The counter saturates and does not wrap.
- **Not defined:** no counter; the last committed values hold indefinitely. `STALE_FRAMES` is ignored.

## Test plan
- **Reset and raster.** Release reset, run 2 frames.
  - hcount wraps 1343→0, vcount wraps 805→0.
  - hsync low exactly for hcount 1048..1183; vsync low exactly for vcount 771..776.
  - blank high exactly for hcount ≥ 1024 or vcount ≥ 768.
  - Frame length is 1,083,264 cycles.
- **Commit timing.** At vcount 100, strobe hand1x = 300, hand1y = 200, grab1 = 1.
  - The bus still shows 512/384/0 until hcount = 1024, vcount = 767, then shows 300/200/1.
  - The values stay constant for the whole next active frame.
- **Clamping.** Strobe hand2x = 4000, hand2y = 2000.
  - After commit, hand2x = 1023 and hand2y = 767.
  - Strobe 1023/767 exactly: bus shows 1023/767 unchanged.
- **Capture on the commit cycle.** Assert `hand_valid` with hand1x = 700 exactly on the hcount = 1023, vcount = 767 cycle, with shadow hand1x = 300.
  - The bus shows 300 this frame and 700 after the next commit.
- **Mid-frame reset.** Assert reset for 1 cycle at vcount 400 with committed hand1x = 300.
  - The next cycle shows hcount = 0, vcount = 0, hand1x = 512, bit 68 = 1.
  - The following cycle shows bit 68 = 0.
- **Stale timeout** (macro defined, `STALE_FRAMES` = 2). Commit hand1x = 300, then stop strobing.
  - The bus keeps 300 for 1 more frame, then shows 512/384 with grabs 0 from the 2nd stale commit.
  - Without the macro, it holds 300 for 5+ frames.
